aquatux_spi_master_n: RTL and testbench
=======================================

AQUATUX_SPI_MASTER_N -- requirements
Module: aquatux_spi_master_n

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving bits per transaction (legal range 2..32).
REQ-002 The block SHALL have parameter N_MISO, default 2, giving the number of parallel MISO channels (legal range 1..8).
REQ-003 The block SHALL have parameter DIV, default 2, giving Clk cycles per SCLK half-period (legal minimum 1).
REQ-004 Clk  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  transaction request, sampled on every Clk edge.
REQ-007 cpol  input  1  SCLK idle level, latched when start is accepted.
REQ-008 cpha  input  1  clock phase, latched when start is accepted.
REQ-009 tx_data  input  DATA_W  word to transmit, MSB first, latched when start is accepted.
REQ-010 busy  output  1  high from the cycle after start is accepted until the done cycle inclusive.
REQ-011 done  output  1  one-cycle pulse marking transaction completion.
REQ-012 rx_data  output  N_MISO*DATA_W  received words; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-013 SCLK  output  1  serial clock.
REQ-014 MOSI  output  1  serial data out.
REQ-015 MOSI_OE  output  1  enable for the external MOSI tri-state buffer; high only while SS_n is low.
REQ-016 MISO  input  N_MISO  serial data in, one bit per channel.
REQ-017 SS_n  output  1  active-low slave select.

Function
REQ-018 The FSM SHALL use states IDLE, LEAD, XFER, TRAIL and SHALL leave IDLE only when start is high in IDLE.
REQ-019 Start while busy SHALL be ignored, and the transaction in progress SHALL be unaffected.
REQ-020 On acceptance, SS_n SHALL fall and busy SHALL rise in the next cycle, and the FSM SHALL enter LEAD for DIV cycles.
REQ-021 XFER SHALL last 2*DIV*DATA_W cycles (DATA_W SCLK periods), then TRAIL SHALL last DIV cycles.
REQ-022 SS_n low time SHALL be exactly 2*DIV*(DATA_W+1) cycles.
REQ-023 On the last TRAIL cycle, done SHALL pulse and rx_data SHALL update; on the next cycle SS_n SHALL go high, busy SHALL go low, and the FSM SHALL be in IDLE.
REQ-024 A start input in the cycle after done SHALL be accepted; the minimum SS_n high time SHALL be 1 cycle.
REQ-025 SCLK SHALL equal the latched cpol outside XFER and SHALL toggle every DIV cycles during XFER, giving exactly 2*DATA_W edges.
REQ-026 In IDLE, the latched cpol SHALL track the cpol input each cycle.
REQ-027 With cpha=0, MOSI SHALL present the MSB from the SS_n fall, MISO SHALL be sampled on leading edges, and MOSI SHALL shift on trailing edges.
REQ-028 With cpha=1, MOSI SHALL shift on leading edges and MISO SHALL be sampled on trailing edges; MOSI SHALL present the MSB from the first leading edge.
REQ-029 Received bits SHALL shift in MSB first, and each channel SHALL use an independent DATA_W shift register.
REQ-030 rx_data SHALL hold its value between transactions.
REQ-031 MOSI SHALL be 0 whenever MOSI_OE is low.

Reset
REQ-032 Reset SHALL act asynchronously and SHALL force IDLE, SS_n=1, SCLK=0, MOSI=0, MOSI_OE=0, busy=0, done=0, rx_data=0, and latched cpol/cpha=0.
REQ-033 Reset mid-transaction SHALL abort without a done pulse, and rx_data SHALL be cleared to 0.
REQ-034 After reset deasserts, the first start SHALL be accepted on the first Clk edge.

Structure
REQ-035 Package aquatux_spi_pkg SHALL hold the FSM state enum and the cpol/cpha mode encodings.
REQ-036 Sub-module aquatux_spi_clk_div SHALL generate the half-period tick (a DIV counter, restarted on state entry).
REQ-037 The bit counter SHALL be $clog2(2*DATA_W+1) bits wide.

Verification
REQ-038 Directed scenario: DATA_W=16, N_MISO=2, DIV=2, mode 0, tx_data=0xA5C3, slave A returns 0x1234, slave B returns 0xBEEF -> MOSI carries 0xA5C3, rx_data=0xBEEF_1234, SS_n low 68 cycles, a single done pulse.
REQ-039 Directed scenario: all four cpol/cpha modes with tx_data=0x8001 -> SCLK idle level correct, 32 SCLK edges, loopback MOSI->MISO returns 0x8001.
REQ-040 Directed scenario: start held high continuously -> back-to-back transactions with SS_n high exactly 1 cycle between them, and start during busy ignored.
REQ-041 Directed scenario: reset asserted at XFER bit 7 -> SS_n=1, SCLK=0, and rx_data=0 immediately, with no done pulse.
REQ-042 Directed scenario: DIV=1, DATA_W=2, N_MISO=1 -> SS_n low 6 cycles, and MOSI_OE coincides with SS_n low.
REQ-043 Directed scenario: cpol input toggled during busy -> SCLK unaffected until IDLE.

Source files
------------

// File: rtl/aquatux_spi_pkg.sv
// Shared types for the aquatux SPI master: FSM states and cpol/cpha mode encodings.
package aquatux_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  // Mode number is {cpol, cpha}.
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  function automatic logic mode_cpol(input spi_mode_e m);
    logic [1:0] v;
    v = m;
    return v[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e m);
    logic [1:0] v;
    v = m;
    return v[0];
  endfunction

endpackage

// File: rtl/aquatux_spi_clk_div.sv
// Half-period tick generator: counts DIV Clk cycles, restarting whenever the FSM changes state.
module aquatux_spi_clk_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic tick_next
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign tick      = (cnt == LAST);
  assign cnt_nxt   = (restart || tick) ? '0 : cnt + CW'(1);
  // Lookahead lets the top register its done pulse for the final half-period.
  assign tick_next = (cnt_nxt == LAST);

  // Half-period counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/aquatux_spi_master_n.sv
// SPI master with one MOSI and N_MISO parallel MISO channels; all outputs registered
// from next-state values so they change only on Clk edges.
module aquatux_spi_master_n
  import aquatux_spi_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_MISO = 2,
  parameter int DIV    = 2
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     cpol,
  input  logic                     cpha,
  input  logic [DATA_W-1:0]        tx_data,
  output logic                     busy,
  output logic                     done,
  output logic [N_MISO*DATA_W-1:0] rx_data,
  output logic                     SCLK,
  output logic                     MOSI,
  output logic                     MOSI_OE,
  input  logic [N_MISO-1:0]        MISO,
  output logic                     SS_n
);

  localparam int BW = $clog2(2 * DATA_W + 1);
  localparam logic [BW-1:0] LAST_EDGE = BW'(2 * DATA_W - 1);

  spi_state_e                state, state_nxt;
  spi_mode_e                 mode, mode_nxt;
  logic [BW-1:0]             edge_cnt, edge_cnt_nxt;
  logic [DATA_W-1:0]         tx_sh, tx_sh_nxt;
  logic [N_MISO*DATA_W-1:0]  rx_sh, rx_sh_nxt, rx_data_nxt;
  logic                      sclk_x, mosi_x, sclk_nxt, mosi_nxt, done_nxt;
  logic                      tick, tick_next, restart;

  assign restart = (state_nxt != state);

  aquatux_spi_clk_div #(.DIV(DIV)) u_clk_div (
    .clk       (Clk),
    .rst       (reset),
    .restart   (restart),
    .tick      (tick),
    .tick_next (tick_next)
  );

  // Next-state, shift registers and serial line values
  always_comb begin
    state_nxt    = state;
    mode_nxt     = mode;
    edge_cnt_nxt = edge_cnt;
    tx_sh_nxt    = tx_sh;
    rx_sh_nxt    = rx_sh;
    sclk_x       = SCLK;
    mosi_x       = MOSI;
    case (state)
      IDLE: begin
        mode_nxt = spi_mode_e'({cpol, cpha});
        if (start) begin
          state_nxt    = LEAD;
          edge_cnt_nxt = '0;
          // cpha=0 must drive the MSB as soon as SS_n falls; cpha=1 waits for the first leading edge.
          if (cpha) begin
            tx_sh_nxt = tx_data;
            mosi_x    = 1'b0;
          end else begin
            tx_sh_nxt = tx_data << 1;
            mosi_x    = tx_data[DATA_W-1];
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      LEAD: begin
        if (tick) begin
          state_nxt = XFER;
        end else begin
          state_nxt = LEAD;
        end
      end
      XFER: begin
        if (tick) begin
          edge_cnt_nxt = edge_cnt + BW'(1);
          sclk_x       = ~SCLK;
          // Even edge_cnt is a leading edge; cpha selects which edge kind shifts vs samples.
          if (edge_cnt[0] != mode_cpha(mode)) begin
            mosi_x    = tx_sh[DATA_W-1];
            tx_sh_nxt = tx_sh << 1;
          end else begin
            for (int k = 0; k < N_MISO; k++) begin
              rx_sh_nxt[k*DATA_W +: DATA_W] = {rx_sh[k*DATA_W +: DATA_W-1], MISO[k]};
            end
          end
          if (edge_cnt == LAST_EDGE) begin
            state_nxt = TRAIL;
          end else begin
            state_nxt = XFER;
          end
        end else begin
          state_nxt = XFER;
        end
      end
      TRAIL: begin
        if (tick) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = TRAIL;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sclk_nxt    = (state_nxt == XFER) ? sclk_x : mode_cpol(mode_nxt);
  assign mosi_nxt    = (state_nxt == IDLE) ? 1'b0 : mosi_x;
  assign done_nxt    = (state_nxt == TRAIL) && tick_next;
  assign rx_data_nxt = done_nxt ? rx_sh_nxt : rx_data;

  // State and output registers
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode     <= MODE0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      MOSI_OE  <= 1'b0;
      SS_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode     <= mode_nxt;
      edge_cnt <= edge_cnt_nxt;
      tx_sh    <= tx_sh_nxt;
      rx_sh    <= rx_sh_nxt;
      rx_data  <= rx_data_nxt;
      SCLK     <= sclk_nxt;
      MOSI     <= mosi_nxt;
      MOSI_OE  <= (state_nxt != IDLE);
      SS_n     <= (state_nxt == IDLE);
      busy     <= (state_nxt != IDLE);
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_aquatux_spi_master_n.sv
// Self-checking bench: behavioural SPI slave/monitor plus directed and random transactions.
module tb_aquatux_spi_master_n;

  localparam int DW  = 16;
  localparam int NM  = 2;
  localparam int DV  = 2;
  localparam int LOW = 2 * DV * (DW + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance signals
  logic             start = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [DW-1:0]    tx = '0;
  logic             busy, done, sclk, mosi, mosi_oe, ss_n;
  logic [NM*DW-1:0] rx;
  logic [NM-1:0]    miso, slave_miso;
  logic             loopback = 1'b0;
  assign miso = loopback ? {NM{mosi}} : slave_miso;

  // small instance signals (DIV=1, DATA_W=2, N_MISO=1), looped back
  logic       start_s = 1'b0, cpol_s = 1'b0, cpha_s = 1'b0;
  logic [1:0] tx_s = '0;
  logic       busy_s, done_s, sclk_s, mosi_s, mosi_oe_s, ss_n_s;
  logic [1:0] rx_s;
  logic [0:0] miso_s;
  assign miso_s = mosi_s;

  aquatux_spi_master_n #(.DATA_W(DW), .N_MISO(NM), .DIV(DV)) dut (
    .Clk(clk), .reset(rst), .start(start), .cpol(cpol), .cpha(cpha), .tx_data(tx),
    .busy(busy), .done(done), .rx_data(rx), .SCLK(sclk), .MOSI(mosi),
    .MOSI_OE(mosi_oe), .MISO(miso), .SS_n(ss_n)
  );

  aquatux_spi_master_n #(.DATA_W(2), .N_MISO(1), .DIV(1)) dut_s (
    .Clk(clk), .reset(rst), .start(start_s), .cpol(cpol_s), .cpha(cpha_s), .tx_data(tx_s),
    .busy(busy_s), .done(done_s), .rx_data(rx_s), .SCLK(sclk_s), .MOSI(mosi_s),
    .MOSI_OE(mosi_oe_s), .MISO(miso_s), .SS_n(ss_n_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural slave: presents its word per SPI mode rules, captures MOSI, counts SCLK edges.
  logic [DW-1:0] sw0 = '0, sw1 = '0, mosi_cap = '0;
  logic          cur_cpha = 1'b0;
  logic          prev_ss_sl = 1'b1, prev_sclk_sl = 1'b0;
  int            ecount = 0, sbit = 0;
  logic          lead, smp;

  always @(sclk or ss_n) begin
    if (ss_n !== prev_ss_sl) begin
      prev_ss_sl = ss_n;
      if (!ss_n) begin
        ecount   = 0;
        sbit     = DW - 1;
        mosi_cap = '0;
        slave_miso = cur_cpha ? 2'b00 : {sw1[DW-1], sw0[DW-1]};
      end
    end else if (sclk !== prev_sclk_sl && !ss_n && !rst) begin
      ecount++;
      lead = (ecount % 2) == 1;
      smp  = cur_cpha ? !lead : lead;
      if (smp) begin
        mosi_cap = {mosi_cap[DW-2:0], mosi};
      end else if (cur_cpha) begin
        if (sbit >= 0) slave_miso = {sw1[sbit], sw0[sbit]};
        sbit--;
      end else begin
        sbit--;
        if (sbit >= 0) slave_miso = {sw1[sbit], sw0[sbit]};
      end
    end
    prev_sclk_sl = sclk;
  end

  // Cycle monitors: SS_n low length, done pulses, MOSI_OE/busy consistency
  int   low_cnt = 0, done_cnt = 0, bad = 0;
  int   low_cnt_s = 0, bad_s = 0;
  logic prev_ss = 1'b1, prev_ss_s = 1'b1;
  always @(negedge clk) begin
    if (!ss_n) low_cnt <= prev_ss ? 1 : low_cnt + 1;
    prev_ss  <= ss_n;
    done_cnt <= done_cnt + (done ? 1 : 0);
    if (!rst && ((mosi_oe !== ~ss_n) || (busy !== ~ss_n) || (!mosi_oe && mosi))) bad <= bad + 1;
    if (!ss_n_s) low_cnt_s <= prev_ss_s ? 1 : low_cnt_s + 1;
    prev_ss_s <= ss_n_s;
    if (!rst && ((mosi_oe_s !== ~ss_n_s) || (busy_s !== ~ss_n_s) || (!mosi_oe_s && mosi_s))) bad_s <= bad_s + 1;
  end

  task automatic wait_done();
    int i;
    i = 0;
    while (!done && i < 400) begin
      @(negedge clk);
      i++;
    end
    #1;
    check("done_timeout", done, 1'b1);
  endtask

  task automatic do_xfer(input logic [DW-1:0] t, input logic pol, input logic pha,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input logic lb);
    int base;
    logic [NM*DW-1:0] exp_rx;
    cpol = pol; cpha = pha; cur_cpha = pha; loopback = lb; sw0 = a; sw1 = b; tx = t;
    exp_rx = lb ? {t, t} : {b, a};
    repeat (3) @(negedge clk);
    check("idle_sclk", sclk, pol);
    base  = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ss_fall", ss_n, 1'b0);
    wait_done();
    check("rx_data", rx, exp_rx);
    check("ss_low_len", low_cnt, LOW);
    check("sclk_edges", ecount, 2 * DW);
    check("mosi_word", mosi_cap, t);
    @(negedge clk);
    #1;
    check("ss_high_after", ss_n, 1'b1);
    check("busy_low_after", busy, 1'b0);
    check("sclk_idle_after", sclk, pol);
    @(negedge clk);
    #1;
    check("single_done", done_cnt - base, 1);
  endtask

  initial begin
    int base;
    int i;
    logic [1:0] mm;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ss_n", ss_n, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_mosi_oe", mosi_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx", rx, '0);
    rst = 1'b0;

    // directed mode-0 transfer with two slaves
    do_xfer(16'hA5C3, 1'b0, 1'b0, 16'h1234, 16'hBEEF, 1'b0);

    // all four modes, loopback
    for (int m = 0; m < 4; m++) begin
      mm = m[1:0];
      do_xfer(16'h8001, mm[1], mm[0], 16'h0000, 16'h0000, 1'b1);
    end

    // random transactions against the slave model
    for (int n = 0; n < 6; n++) begin
      mm = 2'($urandom_range(0, 3));
      do_xfer(16'($urandom), mm[1], mm[0], 16'($urandom), 16'($urandom), 1'b0);
    end

    // start held high: back-to-back with a one-cycle SS_n gap
    cpol = 1'b0; cpha = 1'b0; cur_cpha = 1'b0; loopback = 1'b0;
    sw0 = 16'($urandom); sw1 = 16'($urandom); tx = 16'($urandom);
    repeat (2) @(negedge clk);
    base  = done_cnt;
    start = 1'b1;
    wait_done();
    check("b2b_rx1", rx, {sw1, sw0});
    check("b2b_len1", low_cnt, LOW);
    @(negedge clk);
    check("b2b_gap_ss", ss_n, 1'b1);
    check("b2b_gap_busy", busy, 1'b0);
    @(negedge clk);
    check("b2b_restart", ss_n, 1'b0);
    wait_done();
    start = 1'b0;
    check("b2b_len2", low_cnt, LOW);
    check("b2b_mosi2", mosi_cap, tx);
    repeat (2) @(negedge clk);
    #1;
    check("b2b_done_cnt", done_cnt - base, 2);
    check("b2b_stopped", ss_n, 1'b1);

    // cpol toggled while busy
    cpol = 1'b0; cpha = 1'b0; cur_cpha = 1'b0;
    sw0 = 16'h5A5A; sw1 = 16'hC3C3; tx = 16'h0F0F;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (!done && i < 400) begin
      @(negedge clk);
      cpol = ~cpol;
      i++;
    end
    #1;
    check("cpol_tog_done", done, 1'b1);
    check("cpol_tog_sclk", sclk, 1'b0);
    check("cpol_tog_edges", ecount, 2 * DW);
    check("cpol_tog_rx", rx, 32'hC3C3_5A5A);
    cpol = 1'b1;
    repeat (3) @(negedge clk);
    check("cpol_track_idle", sclk, 1'b1);

    // reset at XFER bit 7
    cpol = 1'b0; cpha = 1'b0; cur_cpha = 1'b0;
    sw0 = 16'($urandom); sw1 = 16'($urandom); tx = 16'($urandom);
    repeat (3) @(negedge clk);
    base  = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (ecount < 14 && i < 400) begin
      @(negedge clk);
      i++;
    end
    check("reach_bit7", ecount, 14);
    #2 rst = 1'b1;
    #1;
    check("abort_ss_n", ss_n, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_rx", rx, '0);
    check("abort_done", done, 1'b0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("abort_no_done", done_cnt - base, 0);
    check("first_start_after_rst", ss_n, 1'b0);
    start = 1'b0;
    wait_done();
    check("post_rst_rx", rx, {sw1, sw0});
    @(negedge clk);
    #1;
    check("post_rst_done_cnt", done_cnt - base, 1);

    // DIV=1, DATA_W=2 instance
    for (int n = 0; n < 4; n++) begin
      mm = 2'($urandom_range(0, 3));
      cpol_s = mm[1]; cpha_s = mm[0];
      tx_s = 2'($urandom);
      repeat (2) @(negedge clk);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      i = 0;
      while (!done_s && i < 50) begin
        @(negedge clk);
        i++;
      end
      #1;
      check("small_done", done_s, 1'b1);
      check("small_low_len", low_cnt_s, 6);
      check("small_rx", rx_s, tx_s);
    end

    repeat (2) @(negedge clk);
    check("oe_ss_consistency", bad, 0);
    check("small_oe_ss_consistency", bad_s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
